// File: rtl/servant_uart_rx.sv
// servant_uart_rx: wishbone-slave UART receiver for the servant SoC.
// Samples an asynchronous serial line (8N1 by default), buffers received bytes
// in a small FIFO and exposes DATA (adr=0) and STATUS (adr=1) registers on a
// cyc-only 32-bit wishbone port with a single-cycle acknowledge.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames with parity
// checking (STATUS[4] = parity error); when undefined STATUS[4] reads 0.
module servant_uart_rx #(
    parameter int CLK_HZ = 32000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rstn,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_rx
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(DEPTH);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and arming
    // ------------------------------------------------------------------
    logic [1:0] rx_pipe;    // [0] metastable stage, [1] synchronized
    logic [1:0] sync_fill;  // marks when rx_pipe[1] holds a real sample
    logic       armed;
    logic       rx_s;

    assign rx_s = rx_pipe[1];

    // Two-flop synchronizer; the line only arms after a genuine high is seen,
    // so a line held low through reset never looks like a start bit.
    always_ff @(posedge wb_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values, regardless of statement order.
        if (!wb_rstn) begin
            rx_pipe   <= 2'b11;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_pipe   <= {rx_pipe[0], i_rx};
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s)
                armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shift, shift_nx;
    logic          push, ferr_set, perr_set;

    // Frame state register; reset aborts any frame in progress.
    always_ff @(posedge wb_clk) begin
        if (!wb_rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
        end
    end

    // Next-state logic: bit timing, sampling and end-of-frame events.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        shift_nx = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !rx_s) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    bit_nx   = '0;
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx   = '0;
                    shift_nx = {rx_s, shift[7:1]};
                    bit_nx   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx = '0;
                    // Even parity: data bits plus parity bit have an even count of ones.
                    if (rx_s != ^shift) begin
                        perr_set = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_STOP;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                    if (rx_s)
                        push = 1'b1;
                    else
                        ferr_set = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO, flags and wishbone slave
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full;
    logic          pop, do_push, ovr_set;
    logic [2:0]    clr;
    logic          ovr, ferr, perr;
    logic [31:0]   status_word;
    logic          unused_dat;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    // Bus side effects happen only in the acknowledge cycle.
    assign pop     = o_wb_ack && !i_wb_we && !i_wb_adr && !empty;
    assign do_push = push && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign clr     = (o_wb_ack && i_wb_we && i_wb_adr) ? i_wb_dat[4:2] : 3'b000;

    assign unused_dat = ^{i_wb_dat[31:5], i_wb_dat[1:0]};

    assign status_word = {20'b0, 4'(count), 3'b0, perr, ferr, ovr, full, !empty};

    // FIFO storage write port.
    always_ff @(posedge wb_clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count define which entries are valid.
        if (do_push)
            mem[wr_ptr] <= shift;
    end

    // FIFO pointers, occupancy and sticky error flags (set beats clear).
    always_ff @(posedge wb_clk) begin
        if (!wb_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
            perr   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            ovr  <= ovr_set  || (ovr  && !clr[0]);
            ferr <= ferr_set || (ferr && !clr[1]);
            perr <= perr_set || (perr && !clr[2]);
        end
    end

    // Single-cycle acknowledge; a held cyc is acked every other cycle.
    always_ff @(posedge wb_clk) begin
        if (!wb_rstn)
            o_wb_ack <= 1'b0;
        else
            o_wb_ack <= i_wb_cyc && !o_wb_ack;
    end

    // Read mux; the bus sees zero whenever no acknowledge is presented.
    always_comb begin
        o_wb_rdt = '0;
        if (o_wb_ack) begin
            if (i_wb_adr)
                o_wb_rdt = status_word;
            else if (!empty)
                o_wb_rdt = {24'b0, mem[rd_ptr]};
        end
    end

endmodule
